// File: rtl/serial_rx_pkg.sv
// Shared definitions for the serial byte receiver: FSM state encoding and
// default frame geometry.
package serial_rx_pkg;

    // Encoding 2'd3 is unused; the FSM treats it as illegal and returns to HUNT.
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } rx_state_e;

    localparam int                    DEF_DATA_W       = 8;
    localparam int                    DEF_SYNC_W       = 4;
    localparam logic [DEF_SYNC_W-1:0] DEF_SYNC_PATTERN = 4'b1011;

endpackage

// File: rtl/serial_byte_rx_if.sv
// Bit-stream input and byte-level output bundle of the serial byte receiver.
// The master drives the bit stream; the slave is the receiver.
interface serial_byte_rx_if
    import serial_rx_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic              din;
    logic              din_en;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              parity_err;
    logic              sync_lock;

    modport master (
        output din, din_en,
        input  dout, dout_valid, parity_err, sync_lock
    );

    modport slave (
        input  din, din_en,
        output dout, dout_valid, parity_err, sync_lock
    );
endinterface

// File: rtl/sync_pattern_det.sv
// Shift register that hunts a serial stream for a fixed sync word (MSB first).
// The match is taken on the post-shift value, so it fires on the last sync bit.
module sync_pattern_det
    import serial_rx_pkg::*;
#(
    parameter int                SYNC_W  = DEF_SYNC_W,
    parameter logic [SYNC_W-1:0] PATTERN = DEF_SYNC_PATTERN
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_en,
    input  logic i_bit,
    output logic o_match
);
    logic [SYNC_W-1:0] r_sr;
    logic [SYNC_W-1:0] w_next;

    assign w_next  = {r_sr[SYNC_W-2:0], i_bit};
    assign o_match = i_en && (w_next == PATTERN);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_sr <= '0;
        end else if (i_en) begin
            r_sr <= w_next;
        end
    end
endmodule

// File: rtl/serial_byte_rx.sv
// Serial byte receiver: locks on a sync word, shifts in DATA_W bits MSB first,
// optionally checks an even-parity bit and emits the byte with a 1-cycle pulse.
module serial_byte_rx
    import serial_rx_pkg::*;
#(
    parameter int                DATA_W       = DEF_DATA_W,
    parameter int                SYNC_W       = DEF_SYNC_W,
    parameter logic [SYNC_W-1:0] SYNC_PATTERN = DEF_SYNC_PATTERN,
    parameter bit                PARITY_EN    = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    serial_byte_rx_if.slave  bus
);
    localparam int               CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    rx_state_e         r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_data_sr;
    logic [DATA_W-1:0] r_dout;
    logic              r_dout_valid;
    logic              r_parity_err;

    logic w_hunt_en;
    logic w_match;
    logic w_frame_done;

    assign w_hunt_en    = bus.din_en && (r_state == HUNT);
    // The detector is cleared on lock so it re-enters HUNT empty and payload
    // bits can never complete a sync word.
    assign w_frame_done = bus.din_en && ((r_state == PARITY) ||
                          (!PARITY_EN && (r_state == DATA) && (r_cnt == LAST_BIT)));

    sync_pattern_det #(
        .SYNC_W  (SYNC_W),
        .PATTERN (SYNC_PATTERN)
    ) u_sync_det (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_match || w_frame_done),
        .i_en    (w_hunt_en),
        .i_bit   (bus.din),
        .o_match (w_match)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= HUNT;
            r_cnt        <= '0;
            r_data_sr    <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_dout_valid <= 1'b0;
            r_parity_err <= 1'b0;
            case (r_state)
                HUNT: begin
                    if (w_match) begin
                        r_state <= DATA;
                        r_cnt   <= '0;
                    end
                end
                DATA: begin
                    if (bus.din_en) begin
                        r_data_sr <= {r_data_sr[DATA_W-2:0], bus.din};
                        r_cnt     <= r_cnt + CNT_W'(1);
                        if (r_cnt == LAST_BIT) begin
                            if (PARITY_EN) begin
                                r_state <= PARITY;
                            end else begin
                                r_dout       <= {r_data_sr[DATA_W-2:0], bus.din};
                                r_dout_valid <= 1'b1;
                                r_state      <= HUNT;
                            end
                        end
                    end
                end
                PARITY: begin
                    if (bus.din_en) begin
                        r_dout       <= r_data_sr;
                        r_dout_valid <= 1'b1;
                        r_parity_err <= (^r_data_sr) ^ bus.din;
                        r_state      <= HUNT;
                    end
                end
                default: r_state <= HUNT;
            endcase
        end
    end

    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.parity_err = r_parity_err;
    assign bus.sync_lock  = (r_state != HUNT);
endmodule

// File: tb/tb_serial_byte_rx.sv
// Self-checking bench for serial_byte_rx: table-driven frames plus hand-written
// sequences for overlapping sync, mid-frame reset and back-to-back frames.
module tb_serial_byte_rx;

    typedef struct {
        logic [7:0] data;
        logic       pbit;
        logic       toggle_en;
        logic [7:0] exp_dout;
        logic       exp_perr;
    } vec_t;

    typedef struct {
        logic [7:0] dout;
        logic       perr;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    exp_t sb[$];
    int   valid_cyc[$];
    vec_t vecs[7];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_byte_rx_if #(.DATA_W(8)) bus ();

    serial_byte_rx #(
        .DATA_W       (8),
        .SYNC_W       (4),
        .SYNC_PATTERN (4'b1011),
        .PARITY_EN    (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every valid pulse must match the oldest pending frame.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (bus.dout_valid === 1'b1) begin
            valid_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                check("spurious_valid", bus.dout_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                check("dout", bus.dout, e.dout);
                check("parity_err", bus.parity_err, e.perr);
            end
        end
    end

    task automatic send_bit(input logic b, input logic en);
        bus.din    = b;
        bus.din_en = en;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic pbit, input logic toggle,
                              input logic [7:0] edout, input logic eperr, input string tag);
        logic [12:0] bits;
        logic        b;
        logic        exp_lock;
        bits = {4'b1011, data, pbit};
        for (int k = 1; k <= 13; k++) begin
            b        = bits[13-k];
            exp_lock = (k >= 4) && (k < 13);
            if (k == 13) sb.push_back('{edout, eperr});
            send_bit(b, 1'b1);
            check($sformatf("%s_lock%0d", tag, k), bus.sync_lock, exp_lock);
            if (toggle) begin
                send_bit(~b, 1'b0);
                check($sformatf("%s_hold%0d", tag, k), bus.sync_lock, exp_lock);
                check($sformatf("%s_hold_valid%0d", tag, k), bus.dout_valid, 1'b0);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0};
        vecs[1] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1};
        vecs[2] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0};
        vecs[3] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h01, 1'b0, 1'b0, 8'h01, 1'b1};
        vecs[5] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0};
        vecs[6] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1};

        // Reset held two cycles with a live strobe: reset must win.
        bus.din    = 1'b1;
        bus.din_en = 1'b1;
        reset      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dout", bus.dout, 8'h00);
        check("rst_valid", bus.dout_valid, 1'b0);
        check("rst_perr", bus.parity_err, 1'b0);
        check("rst_lock", bus.sync_lock, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i].data, vecs[i].pbit, vecs[i].toggle_en,
                       vecs[i].exp_dout, vecs[i].exp_perr, $sformatf("vec%0d", i));
            send_bit(1'b0, 1'b1);
            check($sformatf("vec%0d_pulse_end", i), bus.dout_valid, 1'b0);
            check($sformatf("vec%0d_perr_clr", i), bus.parity_err, 1'b0);
            check($sformatf("vec%0d_dout_held", i), bus.dout, vecs[i].exp_dout);
            check($sformatf("vec%0d_idle_lock", i), bus.sync_lock, 1'b0);
        end

        // Overlapping sync: 1,0,1,0,1,1 locks only on the sixth bit.
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        check("ovl_lock4", bus.sync_lock, 1'b0);
        send_bit(1'b1, 1'b1);
        check("ovl_lock5", bus.sync_lock, 1'b0);
        send_bit(1'b1, 1'b1);
        check("ovl_lock6", bus.sync_lock, 1'b1);
        for (int k = 7; k >= 0; k--) send_bit(k >= 4, 1'b1);
        sb.push_back('{8'hF0, 1'b0});
        send_bit(1'b0, 1'b1);
        check("ovl_lock_end", bus.sync_lock, 1'b0);
        send_bit(1'b0, 1'b1);
        check("ovl_dout", bus.dout, 8'hF0);

        // Reset after five payload bits discards the partial frame.
        for (int k = 0; k < 4; k++) send_bit(k != 1, 1'b1);
        for (int k = 0; k < 5; k++) send_bit(1'b1, 1'b1);
        check("abort_lock_pre", bus.sync_lock, 1'b1);
        reset = 1'b1;
        send_bit(1'b1, 1'b1);
        reset = 1'b0;
        check("abort_lock", bus.sync_lock, 1'b0);
        check("abort_dout", bus.dout, 8'h00);
        check("abort_valid", bus.dout_valid, 1'b0);
        send_frame(8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, "post_abort");
        send_bit(1'b0, 1'b1);
        check("post_abort_dout", bus.dout, 8'hFF);

        // Back-to-back frames, no idle bits: pulses exactly 13 strobes apart.
        valid_cyc.delete();
        send_frame(8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, "b2b_a");
        send_frame(8'h5A, 1'b0, 1'b0, 8'h5A, 1'b0, "b2b_b");
        for (int k = 0; k < 6; k++) begin
            send_bit(1'b0, 1'b1);
            check($sformatf("b2b_idle_lock%0d", k), bus.sync_lock, 1'b0);
        end
        check("b2b_pulses", valid_cyc.size(), 2);
        if (valid_cyc.size() == 2)
            check("b2b_spacing", valid_cyc[1] - valid_cyc[0], 13);
        check("b2b_dout", bus.dout, 8'h5A);

        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
